xram_arbiter: RTL and testbench
===============================

Name: xram_arbiter

Overview:
- Parametrised XRAM bus arbiter: NUM_MASTERS accelerator ports (SHA, AES, ...) share one XRAM through the stb/ack/wr/addr/data handshake.
- Round-robin grant, registered request capture, one outstanding transaction.
- Per-transaction ack timeout with error flag; a hung XRAM cannot deadlock an accelerator.
- Sits between the accelerator tops and the XRAM instance in the multi-accelerator top.

Parameters:
NUM_MASTERS, 2, number of requesting ports (1..8)
ADDR_W, 16, XRAM address width
DATA_W, 8, XRAM data width
TIMEOUT, 255, max cycles in REQ before abort; 0 disables timeout

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
m_stb  input  NUM_MASTERS  per-master request strobe
m_wr  input  NUM_MASTERS  per-master 1=write, 0=read
m_addr  input  NUM_MASTERS*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
m_wdata  input  NUM_MASTERS*DATA_W  master i write data, same packing
m_ack  output  NUM_MASTERS  one-cycle completion pulse to granted master
m_err  output  NUM_MASTERS  one-cycle pulse with m_ack on timeout abort
m_rdata  output  DATA_W  shared read data, valid while m_ack pulses
s_stb  output  1  XRAM request strobe
s_wr  output  1  XRAM write enable
s_addr  output  ADDR_W  XRAM address
s_wdata  output  DATA_W  XRAM write data
s_rdata  input  DATA_W  XRAM read data, sampled with s_ack
s_ack  input  1  XRAM completion
busy  output  1  high in REQ and DONE
grant_id  output  3  index of granted master; held after completion

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; rr pointer=0; timeout counter=0; mask=0.
- States: IDLE, REQ, DONE.
- IDLE:
  - Candidates are m_stb & ~mask.
  - If any: grant g = first candidate scanning from rr pointer upward, wrapping mod NUM_MASTERS.
  - At edge: latch m_wr/m_addr/m_wdata of g into s_wr/s_addr/s_wdata; grant_id=g; s_stb=1; counter=0; go REQ.
  - mask clears after every IDLE cycle.
- REQ:
  - s_stb held 1; s_* fields stable (registered, master changes ignored).
  - counter increments each cycle.
  - s_ack=1 at edge: m_rdata<=s_rdata (writes leave m_rdata unchanged), m_ack[g]<=1, s_stb<=0, go DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: m_ack[g]<=1, m_err[g]<=1, s_stb<=0, go DONE.
  - s_ack wins over timeout in the same cycle.
- DONE (one cycle):
  - m_ack/m_err pulse; rr pointer<=(g+1) mod NUM_MASTERS; mask<=one-hot(g); go IDLE.
- Master rules:
  - Hold stb until ack; drop stb the cycle after ack.
  - The one-cycle mask prevents re-servicing a stale stb.
- s_ack outside REQ is ignored, with no state change.
- Latency: m_stb sampled at cycle t0 -> s_stb high t1 -> XRAM ack at tk (k>=1) -> m_ack at tk+1 -> next grant sampled at tk+2.
  - Minimum 3 cycles per transaction.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0.
- Reset mid-REQ: s_stb drops immediately (async). No m_ack is issued. Pending master re-requests after reset.
- m_ack, m_err: at most one bit high, never high outside DONE.
- grant_id width fixed 3 bits; upper bits 0 when NUM_MASTERS<8.

Test Plan:
- NUM_MASTERS=2: master0 read addr 0x1234, XRAM acks 2 cycles after s_stb with 0xA5 -> s_addr=0x1234, s_wr=0; m_ack[0] one cycle; m_rdata=0xA5; m_ack[1]=0.
- Both masters request at t0 after reset -> master0 granted first, master1 second (rr=1), then rr=0; s_addr matches each master in order.
- Master1 holds m_stb continuously with 8 back-to-back writes, master0 requests mid-stream -> master0 granted after at most one master1 transaction; no master1 write issued twice.
- TIMEOUT=4, XRAM never acks -> s_stb high exactly 4 cycles; m_ack[g] and m_err[g] both pulse once; arbiter returns to IDLE and serves next request.
- rst pulsed low during REQ -> s_stb, busy, m_ack go 0 immediately; after release, grant restarts from master0.
- s_ack pulsed while IDLE -> no m_ack, no state change; s_ack and timeout in the same cycle -> m_ack=1, m_err=0.

Source files
------------

// File: rtl/xram_arbiter_if.sv
// XRAM arbiter bus bundle: accelerator-side request/ack signals, XRAM-side
// handshake and arbiter status. The arbiter uses the slave view, the environment the master view.
interface xram_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8
);
    // accelerator side, master i packed at [i*W +: W]
    logic [NUM_MASTERS-1:0]        m_stb;
    logic [NUM_MASTERS-1:0]        m_wr;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]        m_ack;
    logic [NUM_MASTERS-1:0]        m_err;
    logic [DATA_W-1:0]             m_rdata;

    // XRAM side
    logic                          s_stb;
    logic                          s_wr;
    logic [ADDR_W-1:0]             s_addr;
    logic [DATA_W-1:0]             s_wdata;
    logic [DATA_W-1:0]             s_rdata;
    logic                          s_ack;

    // status
    logic                          busy;
    logic [2:0]                    grant_id;

    modport slave (
        input  m_stb, m_wr, m_addr, m_wdata, s_rdata, s_ack,
        output m_ack, m_err, m_rdata, s_stb, s_wr, s_addr, s_wdata, busy, grant_id
    );

    modport master (
        output m_stb, m_wr, m_addr, m_wdata, s_rdata, s_ack,
        input  m_ack, m_err, m_rdata, s_stb, s_wr, s_addr, s_wdata, busy, grant_id
    );
endinterface

// File: rtl/xram_arbiter.sv
// Round-robin arbiter sharing one XRAM between NUM_MASTERS accelerators, one
// outstanding transaction at a time, with a per-transaction ack timeout.
module xram_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          rst,
    xram_arbiter_if.slave bus
);
    localparam int unsigned      GID_W    = 3;
    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [GID_W-1:0] GID_LAST = GID_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q,   state_d;
    logic [GID_W-1:0]       rr_q,      rr_d;
    logic [NUM_MASTERS-1:0] mask_q,    mask_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [GID_W-1:0]       gid_q,     gid_d;
    logic                   s_stb_q,   s_stb_d;
    logic                   s_wr_q,    s_wr_d;
    logic [ADDR_W-1:0]      s_addr_q,  s_addr_d;
    logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]      m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0] m_ack_q,   m_ack_d;
    logic [NUM_MASTERS-1:0] m_err_q,   m_err_d;
    logic                   busy_q,    busy_d;

    logic [NUM_MASTERS-1:0] cand_c;
    logic                   found_c;
    logic [GID_W-1:0]       pick_c;
    logic                   pick_wr_c;
    logic [ADDR_W-1:0]      pick_addr_c;
    logic [DATA_W-1:0]      pick_wdata_c;
    logic [NUM_MASTERS-1:0] gid_oh_c;

    // One-hot decode of the granted master, used for ack/err and the stale-stb mask
    always_comb begin
        gid_oh_c = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            gid_oh_c[k] = (GID_W'(k) == gid_q);
        end
    end

    // First unmasked requester scanning upward from the round-robin pointer
    always_comb begin
        int unsigned j;
        j            = 0;
        cand_c       = bus.m_stb & ~mask_q;
        found_c      = 1'b0;
        pick_c       = '0;
        pick_wr_c    = 1'b0;
        pick_addr_c  = '0;
        pick_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            j = 32'(rr_q) + i;
            if (j >= NUM_MASTERS) begin
                j = j - NUM_MASTERS;
            end
            for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                if (!found_c && (k == j) && cand_c[k]) begin
                    found_c      = 1'b1;
                    pick_c       = GID_W'(k);
                    pick_wr_c    = bus.m_wr[k];
                    pick_addr_c  = bus.m_addr[k*ADDR_W +: ADDR_W];
                    pick_wdata_c = bus.m_wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        gid_d     = gid_q;
        s_stb_d   = s_stb_q;
        s_wr_d    = s_wr_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_ack_d   = '0;
        m_err_d   = '0;

        unique case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                if (found_c) begin
                    s_stb_d   = 1'b1;
                    s_wr_d    = pick_wr_c;
                    s_addr_d  = pick_addr_c;
                    s_wdata_d = pick_wdata_c;
                    gid_d     = pick_c;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.s_ack) begin
                    if (!s_wr_q) begin
                        m_rdata_d = bus.s_rdata;
                    end
                    m_ack_d = gid_oh_c;
                    s_stb_d = 1'b0;
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    m_ack_d = gid_oh_c;
                    m_err_d = gid_oh_c;
                    s_stb_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_d    = (gid_q == GID_LAST) ? '0 : gid_q + GID_W'(1);
                mask_d  = gid_oh_c;
                state_d = ST_IDLE;
            end
            default: begin
                s_stb_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            gid_q     <= '0;
            s_stb_q   <= 1'b0;
            s_wr_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_ack_q   <= '0;
            m_err_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            gid_q     <= gid_d;
            s_stb_q   <= s_stb_d;
            s_wr_q    <= s_wr_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.s_stb    = s_stb_q;
    assign bus.s_wr     = s_wr_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.m_rdata  = m_rdata_q;
    assign bus.m_ack    = m_ack_q;
    assign bus.m_err    = m_err_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = gid_q;
endmodule

// File: tb/tb_xram_arbiter.sv
// Directed bench for xram_arbiter: two masters, TIMEOUT=4, hand-computed
// expectations for grant order, handshake timing, timeout and reset.
module tb_xram_arbiter;
    localparam int unsigned NM = 2;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xram_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    xram_arbiter #(
        .NUM_MASTERS(NM),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.m_stb  = '0;
        bus.s_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_a [9];
        logic [2:0]  exp_g [9];
        int k, e, cyc, stb_cnt, ack_cnt;

        bus.m_stb   = '0;
        bus.m_wr    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_rdata = '0;
        bus.s_ack   = 1'b0;

        // ---- reset state and single read by master0
        do_reset();
        check("rst_s_stb",    32'(bus.s_stb),    0);
        check("rst_busy",     32'(bus.busy),     0);
        check("rst_m_ack",    32'(bus.m_ack),    0);
        check("rst_grant_id", 32'(bus.grant_id), 0);

        bus.m_addr[0 +: AW] = 16'h1234;
        bus.m_wr            = 2'b00;
        bus.m_stb           = 2'b01;
        step();
        check("rd_s_stb",  32'(bus.s_stb),    1);
        check("rd_s_addr", 32'(bus.s_addr),   'h1234);
        check("rd_s_wr",   32'(bus.s_wr),     0);
        check("rd_grant",  32'(bus.grant_id), 0);
        check("rd_busy",   32'(bus.busy),     1);
        step();
        check("rd_s_stb_hold", 32'(bus.s_stb), 1);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 8'hA5;
        step();
        bus.s_ack = 1'b0;
        check("rd_m_ack",   32'(bus.m_ack),   'h1);
        check("rd_m_rdata", 32'(bus.m_rdata), 'hA5);
        check("rd_m_err",   32'(bus.m_err),   0);
        check("rd_s_stb_lo", 32'(bus.s_stb),  0);
        check("rd_done_busy", 32'(bus.busy),  1);
        step();
        check("rd_ack_pulse", 32'(bus.m_ack), 0);
        check("rd_idle_busy", 32'(bus.busy),  0);
        step();
        check("stale_masked_busy",  32'(bus.busy),  0);
        check("stale_masked_s_stb", 32'(bus.s_stb), 0);
        bus.m_stb = 2'b00;

        // ---- both masters request after reset: round-robin order
        do_reset();
        bus.m_addr[0 +: AW]  = 16'h1000;
        bus.m_addr[AW +: AW] = 16'h2000;
        bus.m_wdata[DW +: DW] = 8'h5C;
        bus.m_wr  = 2'b10;
        bus.m_stb = 2'b11;
        step();
        check("rr_first_grant", 32'(bus.grant_id), 0);
        check("rr_first_addr",  32'(bus.s_addr),   'h1000);
        check("rr_first_wr",    32'(bus.s_wr),     0);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 8'h11;
        step();
        bus.s_ack = 1'b0;
        check("rr_first_ack",   32'(bus.m_ack),   'h1);
        check("rr_first_rdata", 32'(bus.m_rdata), 'h11);
        bus.m_stb = 2'b10;
        step();
        step();
        check("rr_second_grant", 32'(bus.grant_id), 1);
        check("rr_second_addr",  32'(bus.s_addr),   'h2000);
        check("rr_second_wr",    32'(bus.s_wr),     1);
        check("rr_second_wdata", 32'(bus.s_wdata),  'h5C);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 8'hEE;
        step();
        bus.s_ack = 1'b0;
        check("rr_second_ack",  32'(bus.m_ack),   'h2);
        check("wr_keeps_rdata", 32'(bus.m_rdata), 'h11);
        bus.m_stb = 2'b11;
        step();
        step();
        check("rr_wrap_grant", 32'(bus.grant_id), 0);
        check("rr_wrap_addr",  32'(bus.s_addr),   'h1000);
        bus.s_ack = 1'b1;
        step();
        bus.s_ack = 1'b0;
        bus.m_stb = 2'b00;
        step();
        step();

        // ---- master1 streams 8 writes, master0 cuts in after the 2nd
        exp_a = '{16'h3000, 16'h3001, 16'h0ABC, 16'h3002, 16'h3003,
                  16'h3004, 16'h3005, 16'h3006, 16'h3007};
        exp_g = '{3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        k = 0;
        e = 0;
        cyc = 0;
        bus.s_rdata           = 8'h77;
        bus.m_wr              = 2'b10;
        bus.m_addr[AW +: AW]  = 16'h3000;
        bus.m_wdata[DW +: DW] = 8'h00;
        bus.m_stb             = 2'b10;
        while (k < 8 && cyc < 200) begin
            step();
            cyc++;
            if (bus.s_stb && !bus.s_ack) begin
                if (e < 9) begin
                    check($sformatf("b2b_addr%0d", e),  32'(bus.s_addr),   32'(exp_a[e]));
                    check($sformatf("b2b_grant%0d", e), 32'(bus.grant_id), 32'(exp_g[e]));
                    if (bus.grant_id == 3'd1) begin
                        check($sformatf("b2b_wdata%0d", e), 32'(bus.s_wdata), 32'(k));
                    end
                end
                e++;
                bus.s_ack = 1'b1;
            end else begin
                bus.s_ack = 1'b0;
            end
            if (bus.m_ack[1]) begin
                k++;
                if (k < 8) begin
                    bus.m_addr[AW +: AW]  = 16'h3000 + 16'(k);
                    bus.m_wdata[DW +: DW] = 8'(k);
                end else begin
                    bus.m_stb[1] = 1'b0;
                end
                if (k == 2) begin
                    bus.m_addr[0 +: AW] = 16'h0ABC;
                    bus.m_wr[0]         = 1'b0;
                    bus.m_stb[0]        = 1'b1;
                end
            end
            if (bus.m_ack[0]) begin
                check("b2b_m0_rdata", 32'(bus.m_rdata), 'h77);
                bus.m_stb[0] = 1'b0;
            end
        end
        bus.s_ack = 1'b0;
        check("b2b_writes_done", 32'(k), 8);
        check("b2b_issue_count", 32'(e), 9);
        bus.m_stb = 2'b00;
        step();
        step();

        // ---- XRAM never acks: timeout abort after 4 REQ cycles
        bus.m_addr[0 +: AW] = 16'h4444;
        bus.m_wr  = 2'b00;
        bus.m_stb = 2'b01;
        stb_cnt = 0;
        ack_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.s_stb) stb_cnt++;
            if (bus.m_ack != '0) begin
                ack_cnt++;
                check("to_ack_vec", 32'(bus.m_ack), 'h1);
                check("to_err_vec", 32'(bus.m_err), 'h1);
                bus.m_stb = 2'b00;
            end
        end
        check("to_s_stb_cycles", 32'(stb_cnt), 4);
        check("to_ack_pulses",   32'(ack_cnt), 1);
        check("to_idle_busy",    32'(bus.busy), 0);
        bus.m_addr[AW +: AW] = 16'h5555;
        bus.m_stb = 2'b10;
        step();
        check("to_next_grant", 32'(bus.grant_id), 1);
        check("to_next_addr",  32'(bus.s_addr),   'h5555);
        bus.s_ack = 1'b1;
        step();
        bus.s_ack = 1'b0;
        check("to_next_ack", 32'(bus.m_ack), 'h2);
        check("to_next_err", 32'(bus.m_err), 0);
        bus.m_stb = 2'b00;
        step();
        step();

        // ---- asynchronous reset in the middle of REQ
        bus.m_addr[AW +: AW] = 16'h6000;
        bus.m_stb = 2'b10;
        step();
        check("arst_pre_s_stb", 32'(bus.s_stb),    1);
        check("arst_pre_grant", 32'(bus.grant_id), 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_s_stb", 32'(bus.s_stb),    0);
        check("arst_busy",  32'(bus.busy),     0);
        check("arst_m_ack", 32'(bus.m_ack),    0);
        check("arst_grant", 32'(bus.grant_id), 0);
        bus.m_addr[0 +: AW] = 16'h7000;
        bus.m_stb = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("arst_restart_grant", 32'(bus.grant_id), 0);
        check("arst_restart_addr",  32'(bus.s_addr),   'h7000);
        bus.s_ack = 1'b1;
        step();
        bus.s_ack = 1'b0;
        check("arst_restart_ack", 32'(bus.m_ack), 'h1);
        bus.m_stb = 2'b00;
        step();
        step();

        // ---- s_ack while IDLE is ignored
        bus.s_ack = 1'b1;
        step();
        bus.s_ack = 1'b0;
        check("idle_ack_m_ack", 32'(bus.m_ack), 0);
        check("idle_ack_busy",  32'(bus.busy),  0);
        check("idle_ack_s_stb", 32'(bus.s_stb), 0);

        // ---- s_ack on the timeout cycle: ack wins, no error
        bus.m_addr[0 +: AW] = 16'h0101;
        bus.m_wr  = 2'b00;
        bus.m_stb = 2'b01;
        step();
        step();
        step();
        step();
        check("race_s_stb", 32'(bus.s_stb), 1);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 8'h3C;
        step();
        bus.s_ack = 1'b0;
        check("race_m_ack",   32'(bus.m_ack),   'h1);
        check("race_m_err",   32'(bus.m_err),   0);
        check("race_m_rdata", 32'(bus.m_rdata), 'h3C);
        bus.m_stb = 2'b00;
        step();
        check("race_idle_busy", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
